multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel countdown timer for the lab datapath. Each of NCH independent channels loads a scaled reload value (load_val << scale), counts down on a shared tick enable, and emits a one-cycle done pulse on expiry. Each channel runs one-shot or periodic, chosen at start. It replaces per-use fixed-period timers in the game/control FSMs that need beats, timeouts and blink rates.

## Interface
- NCH, 2: number of independent channels (≥1).
- LOAD_W, 4: width of each channel's load value.
- SHIFT_W, 3: width of each channel's scale (left-shift amount, 0..2**SHIFT_W-1).
- CNT_W, 11: counter width. Must be ≥ LOAD_W + 2**SHIFT_W - 1; a violating parameter set must fail elaboration.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  shared count enable; a running channel decrements only in cycles with tick=1.
- start  in  NCH  per-channel start/restart request, level-sampled each cycle.
- stop  in  NCH  per-channel abort.
- periodic  in  NCH  mode, sampled with start: 1 = auto-reload, 0 = one-shot.
- load_val  in  NCH*LOAD_W  packed; channel i at [i*LOAD_W +: LOAD_W].
- scale  in  NCH*SHIFT_W  packed; channel i at [i*SHIFT_W +: SHIFT_W].
- done  out  NCH  registered one-cycle expiry pulse per channel.
- busy  out  NCH  registered; 1 while the channel is in RUN.
- count  out  NCH*CNT_W  packed current count per channel; 0 when idle.

## Operation
- Reload R_i = zero-extend(load_val_i, CNT_W) << scale_i. R_i is exact, with no truncation, because of the CNT_W constraint. An R_i of 0 is treated as 1.
- Each channel has two states, IDLE and RUN. It stores count, a periodic flag, and R_i latched at start. Later changes to load_val, scale or periodic do not affect a running channel until the next start.
- In IDLE, start=1 moves the channel to RUN with count=R_i, latching R_i and the periodic flag. A tick in the same cycle is ignored.
- In RUN, the checks below apply in priority order:
  - stop=1: go to IDLE with count=0. No done pulse.
  - start=1: restart with count=R_i and relatch the mode. No done pulse, even if the channel would have expired this cycle.
  - tick=1 and count>1: count decrements by 1.
  - tick=1 and count==1: this is expiry. done=1 next cycle. If periodic, count reloads to the latched R and the channel stays in RUN. If one-shot, the channel goes to IDLE with count=0.
  - tick=0: count holds.
- In IDLE, stop has no effect. If start and stop are both 1, stop wins and the channel stays or goes IDLE.
- Channels are fully independent. Simultaneous expiries on several channels each pulse their own done bit in the same cycle.

## Timing
- Reset values: done=0, busy=0, count=0, all channels IDLE with periodic flags cleared. rst overrides start, stop and tick in the same cycle. rst mid-run aborts with no done pulse.
- Start: if start is sampled at edge k, busy=1 and count=R from edge k onward.
- Latency with tick held at 1: done is high in the cycle after edge k+R, i.e. R cycles after busy rises.
- One-shot: busy falls at the same edge at which done rises.
- Periodic with tick continuous: done pulses every R cycles. With R=1, done stays high every cycle while running.
- With a sparse tick, expiry occurs on the R-th tick after start. done is still a single clk-cycle pulse.
- done is never high for two consecutive cycles, except in periodic mode with R=1 and tick continuous.

## Test plan
- Reset then one-shot: ch0 load_val=3, scale=2 (R=12), periodic=0, tick=1 continuous, start pulse → count 12,11,…,1; done0 pulses once 12 cycles after busy0 rises; busy0 falls on the same edge; count0=0 afterwards.
- Periodic with sparse tick: ch1 load_val=5, scale=0, periodic=1, tick every 4th cycle → done1 pulses every 20 clk cycles; busy1 stays 1 and count1 reloads to 5.
- Max reload: load_val=15, scale=7 → count=1920 exactly, no truncation; expiry after 1920 ticks.
- Boundary conditions:
  - stop at count=1 together with tick → IDLE, no done.
  - start while running at count=1 together with tick → count=R, no done.
  - start and stop in the same cycle → stays IDLE.
  - load_val=0 → behaves as R=1.
- Independence and reset: both channels expire on the same tick → done=2'b11 for one cycle. Assert rst mid-run → next cycle done=0, busy=0, count=0. Changing load_val while running leaves the current period unchanged.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: NCH independent countdown timers with scaled reload, one-shot or periodic
module multi_timer #(
  parameter int NCH     = 2,
  parameter int LOAD_W  = 4,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [NCH-1:0]          start,
  input  logic [NCH-1:0]          stop,
  input  logic [NCH-1:0]          periodic,
  input  logic [NCH*LOAD_W-1:0]   load_val,
  input  logic [NCH*SHIFT_W-1:0]  scale,
  output logic [NCH-1:0]          done,
  output logic [NCH-1:0]          busy,
  output logic [NCH*CNT_W-1:0]    count
);
  typedef enum logic {IDLE, RUN} state_e;
  if (CNT_W < LOAD_W + 2**SHIFT_W - 1) begin : g_bad
    $error("multi_timer: CNT_W too small for LOAD_W and SHIFT_W");
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, rel_q, rel_d, sh, r;
    logic per_q, per_d, done_q, done_d;
    assign sh = CNT_W'(load_val[i*LOAD_W +: LOAD_W]) << scale[i*SHIFT_W +: SHIFT_W];
    assign r  = (sh == '0) ? CNT_W'(1) : sh;
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      rel_d  = rel_q;
      per_d  = per_q;
      done_d = 1'b0;
      if (stop[i]) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else if (start[i]) begin
        st_d  = RUN;
        cnt_d = r;
        rel_d = r;
        per_d = periodic[i];
      end else if (st_q == RUN && tick) begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          done_d = 1'b1;
          st_d   = per_q ? RUN : IDLE;
          cnt_d  = per_q ? rel_q : '0;
        end
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        rel_q  <= '0;
        per_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        rel_q  <= rel_d;
        per_q  <= per_d;
        done_q <= done_d;
      end
    end
    assign done[i]                  = done_q;
    assign busy[i]                  = st_q == RUN;
    assign count[i*CNT_W +: CNT_W]  = cnt_q;
  end
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed scoreboard bench for multi_timer
module tb_multi_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic [1:0] start = '0, stop = '0, periodic = '0;
  logic [7:0] load_val = '0;
  logic [5:0] scale = '0;
  logic [1:0] done, busy;
  logic [21:0] count;
  logic [25:0] exp_q[$];
  string tag_q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  multi_timer #(.NCH(2), .LOAD_W(4), .SHIFT_W(3), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .periodic(periodic),
    .load_val(load_val), .scale(scale), .done(done), .busy(busy), .count(count)
  );
  task automatic step(input string tag, input logic [1:0] d, input logic [1:0] b,
                      input logic [10:0] c1, input logic [10:0] c0);
    logic [25:0] e, o;
    string t;
    exp_q.push_back({d, b, c1, c0});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {done, busy, count};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got done=%b busy=%b count1=%0d count0=%0d, want done=%b busy=%b count1=%0d count0=%0d",
             t, o[25:24], o[23:22], o[21:11], o[10:0], e[25:24], e[23:22], e[21:11], e[10:0]);
    end
  endtask
  initial begin
    step("reset", 2'b00, 2'b00, 0, 0);
    rst = 1'b0;
    load_val = 8'h03; scale = 6'o02; periodic = 2'b00; tick = 1'b1; start = 2'b01;
    step("os_start", 2'b00, 2'b01, 0, 12);
    start = 2'b00; load_val = 8'h07; scale = 6'o00;
    for (int j = 11; j >= 1; j--) step($sformatf("os_cnt%0d", j), 2'b00, 2'b01, 0, 11'(j));
    step("os_done", 2'b01, 2'b00, 0, 0);
    step("os_idle", 2'b00, 2'b00, 0, 0);
    tick = 1'b0; load_val = 8'h50; scale = 6'o00; periodic = 2'b10; start = 2'b10;
    step("per_start", 2'b00, 2'b10, 5, 0);
    start = 2'b00; periodic = 2'b00;
    for (int m = 1; m <= 40; m++) begin
      int t;
      tick = (m % 4 == 0);
      t = m / 4;
      step($sformatf("per_m%0d", m), (tick && t % 5 == 0) ? 2'b10 : 2'b00, 2'b10, 11'(5 - t % 5), 0);
    end
    tick = 1'b0; stop = 2'b10;
    step("per_stop", 2'b00, 2'b00, 0, 0);
    stop = 2'b00;
    load_val = 8'h0f; scale = 6'o07; start = 2'b01;
    step("max_start", 2'b00, 2'b01, 0, 1920);
    start = 2'b00; tick = 1'b1;
    for (int j = 1; j < 1920; j++) step($sformatf("max_t%0d", j), 2'b00, 2'b01, 0, 11'(1920 - j));
    step("max_done", 2'b01, 2'b00, 0, 0);
    tick = 1'b0; load_val = 8'h02; scale = 6'o00; start = 2'b01;
    step("stp_start", 2'b00, 2'b01, 0, 2);
    start = 2'b00; tick = 1'b1;
    step("stp_one", 2'b00, 2'b01, 0, 1);
    stop = 2'b01;
    step("stp_at1", 2'b00, 2'b00, 0, 0);
    stop = 2'b00;
    step("stp_nodone", 2'b00, 2'b00, 0, 0);
    tick = 1'b0; start = 2'b01;
    step("rs_start", 2'b00, 2'b01, 0, 2);
    start = 2'b00; tick = 1'b1;
    step("rs_one", 2'b00, 2'b01, 0, 1);
    start = 2'b01;
    step("rs_restart", 2'b00, 2'b01, 0, 2);
    start = 2'b00;
    step("rs_one2", 2'b00, 2'b01, 0, 1);
    step("rs_done", 2'b01, 2'b00, 0, 0);
    start = 2'b01; stop = 2'b01;
    step("ss_idle", 2'b00, 2'b00, 0, 0);
    start = 2'b00; stop = 2'b00;
    load_val = 8'h00; scale = 6'o03; periodic = 2'b01; start = 2'b01;
    step("z_start", 2'b00, 2'b01, 0, 1);
    start = 2'b00; periodic = 2'b00;
    step("z_exp1", 2'b01, 2'b01, 0, 1);
    step("z_exp2", 2'b01, 2'b01, 0, 1);
    stop = 2'b01;
    step("z_stop", 2'b00, 2'b00, 0, 0);
    stop = 2'b00; tick = 1'b0; load_val = 8'h33; scale = 6'o00; start = 2'b11;
    step("sim_start", 2'b00, 2'b11, 3, 3);
    start = 2'b00; tick = 1'b1;
    step("sim_2", 2'b00, 2'b11, 2, 2);
    step("sim_1", 2'b00, 2'b11, 1, 1);
    step("sim_done", 2'b11, 2'b00, 0, 0);
    step("sim_after", 2'b00, 2'b00, 0, 0);
    periodic = 2'b11; start = 2'b11;
    step("rst_start", 2'b00, 2'b11, 3, 3);
    start = 2'b00;
    step("rst_2", 2'b00, 2'b11, 2, 2);
    step("rst_1", 2'b00, 2'b11, 1, 1);
    rst = 1'b1;
    step("rst_mid", 2'b00, 2'b00, 0, 0);
    rst = 1'b0;
    step("rst_after", 2'b00, 2'b00, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
